// File: rtl/sub_pkg.sv
// Shared types and widths for the two-stage pipelined subtractor (sub_2p).
// WIDTH_C : operand/result width
// LO_W_C  : low slice width resolved in stage 1
// HI_W_C  : high slice width resolved in stage 2
// s1_t    : stage-1 payload (low-slice result plus untouched high operands)
// s2_t    : stage-2 payload (final difference and borrow)
package sub_pkg;

  localparam int unsigned WIDTH_C = 15;
  localparam int unsigned LO_W_C  = 8;
  localparam int unsigned HI_W_C  = WIDTH_C - LO_W_C;

  typedef struct packed {
    logic [LO_W_C-1:0] lo_diff;
    logic              lo_borrow;
    logic [HI_W_C-1:0] x_hi;
    logic [HI_W_C-1:0] y_hi;
  } s1_t;

  typedef struct packed {
    logic [WIDTH_C-1:0] diff;
    logic               borrow;
  } s2_t;

endpackage

// File: rtl/sub_2p_pipe_stage.sv
// pipe_stage: one valid/ready register slice of width DW.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   up_valid    : upstream has data this cycle
//   up_ready_c  : slice loads on this edge (combinational)
//   up_data     : upstream payload
//   dn_valid    : registered valid toward downstream
//   dn_ready    : downstream accepts this cycle
//   dn_data     : registered payload toward downstream
module pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready_c,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  // Load when empty or when the held item leaves this edge.
  assign up_ready_c = !dn_valid || dn_ready;

  // Valid follows upstream on a load; data only captured when meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready_c) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/sub_2p.sv
// sub_2p: two-stage pipelined unsigned subtractor, diff = X - Y, with
// valid/ready handshakes on both sides. Stage 1 resolves the low LO_W bits,
// stage 2 resolves the high bits using the low borrow.
// Optional build macro SUB_SATURATE_EN: clamp diff to 0 on underflow
// (borrow still reports 1).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   X, Y                 : minuend, subtrahend
//   in_valid / in_ready  : input handshake (in_ready depends on out_ready)
//   diff, borrow         : registered result, borrow = (X < Y)
//   out_valid / out_ready: output handshake
module sub_2p
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_C,
  parameter int unsigned LO_W  = LO_W_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  s1_t         s1_d;
  s1_t         s1_q;
  s2_t         s2_d;
  s2_t         s2_q;
  logic        s1_valid;
  logic        s1_ready_c;
  logic        s2_ready_c;
  logic [LO_W:0] lo_full;
  logic [HI_W:0] hi_full;

  // Stage 1 input: low-slice subtract, high operands passed through.
  always_comb begin
    lo_full        = {1'b0, X[LO_W-1:0]} - {1'b0, Y[LO_W-1:0]};
    s1_d           = '0;
    s1_d.lo_diff   = lo_full[LO_W-1:0];
    s1_d.lo_borrow = lo_full[LO_W];
    s1_d.x_hi      = X[WIDTH-1:LO_W];
    s1_d.y_hi      = Y[WIDTH-1:LO_W];
  end

  pipe_stage #(.DW($bits(s1_t))) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (in_valid),
    .up_ready_c (s1_ready_c),
    .up_data    (s1_d),
    .dn_valid   (s1_valid),
    .dn_ready   (s2_ready_c),
    .dn_data    (s1_q)
  );

  // Stage 2 input: high-slice subtract consuming the low borrow.
  always_comb begin
    hi_full     = {1'b0, s1_q.x_hi} - {1'b0, s1_q.y_hi} - (HI_W+1)'(s1_q.lo_borrow);
    s2_d        = '0;
    s2_d.borrow = hi_full[HI_W];
    s2_d.diff   = {hi_full[HI_W-1:0], s1_q.lo_diff};
`ifdef SUB_SATURATE_EN
    if (hi_full[HI_W]) begin
      s2_d.diff = '0;
    end
`endif
  end

  pipe_stage #(.DW($bits(s2_t))) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (s1_valid),
    .up_ready_c (s2_ready_c),
    .up_data    (s2_d),
    .dn_valid   (out_valid),
    .dn_ready   (out_ready),
    .dn_data    (s2_q)
  );

  // Never advertise acceptance while reset is held.
  assign in_ready = s1_ready_c && !rst;
  assign diff     = s2_q.diff;
  assign borrow   = s2_q.borrow;

endmodule

// File: tb/tb_sub_2p.sv
// Bench for sub_2p: directed scenarios plus randomized traffic scored
// against a transaction-level model (queue of expected results).
module tb_sub_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] x;
  logic [14:0] y;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] diff;
  logic        borrow;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_out   = 0;
  bit          chk_ready = 1'b0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  sub_2p dut (
    .clk       (clk),
    .rst       (rst),
    .X         (x),
    .Y         (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .borrow    (borrow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Expected {borrow, diff} from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [14:0] a, input logic [14:0] b);
    int   d;
    logic bw;
    d  = int'(a) - int'(b);
    bw = (a < b);
    if (d < 0) d += 32768;
`ifdef SUB_SATURATE_EN
    if (bw) d = 0;
`endif
    return {bw, 15'(d)};
  endfunction

  // Scoreboard: sample handshakes mid-cycle; occupancy equals queue depth.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (chk_ready)
        check("in_ready_model", 32'(in_ready), 32'(!(sb_q.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) check("sb_unexpected_out", 32'(1), 32'(0));
        else check("sb_result", 32'({borrow, diff}), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(model(x, y));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input logic [14:0] ed, input logic eb);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] px[5];
    logic [14:0] py[5];
    logic [15:0] m0;
    int idx, acc_early, cyc, out0;
    bit hold;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_diff", 32'(diff), 32'(0));
    check("reset_borrow", 32'(borrow), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(0));
    step(); rst = 1'b0; out_ready = 1'b1;

    // Single operation latency and one-cycle output pulse.
    step(); x = 15'd10; y = 15'd0; in_valid = 1'b1;
    @(negedge clk); check("t1_in_ready", 32'(in_ready), 32'(1));
    step(); in_valid = 1'b0;
    @(negedge clk); check("t1_lat1_valid", 32'(out_valid), 32'(0));
    step();
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'(1));
    check("t1_diff", 32'(diff), 32'(10));
    check("t1_borrow", 32'(borrow), 32'(0));
    step();
    @(negedge clk); check("t1_pulse_end", 32'(out_valid), 32'(0));

    // Back-to-back, second exercises low-to-high borrow.
    step(); x = 15'd2002; y = 15'd2002; in_valid = 1'b1;
    step(); x = 15'd256;  y = 15'd1;
    step(); in_valid = 1'b0;
    wait_out("t2a", 15'd0, 1'b0);
    wait_out("t2b", 15'd255, 1'b0);

    // Underflow.
    step(); x = 15'd2002; y = 15'd2047; in_valid = 1'b1;
    step(); in_valid = 1'b0;
`ifdef SUB_SATURATE_EN
    wait_out("t3", 15'd0, 1'b1);
`else
    wait_out("t3", 15'd32723, 1'b1);
`endif
    repeat (3) step();

    // Stall with out_ready low for 4 cycles, then drain.
    for (int i = 0; i < 5; i++) begin
      px[i] = 15'($urandom);
      py[i] = 15'($urandom);
    end
    m0 = model(px[0], py[0]);
    idx = 0; acc_early = 0; cyc = 0; out0 = int'(n_out);
    while ((idx < 5 || sb_q.size() != 0) && cyc < 60) begin
      step();
      out_ready = (cyc >= 4);
      in_valid  = (idx < 5);
      if (idx < 5) begin x = px[idx]; y = py[idx]; end
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        check("t4_stall_in_ready", 32'(in_ready), 32'(0));
        check("t4_held_valid", 32'(out_valid), 32'(1));
        check("t4_held_diff", 32'({borrow, diff}), 32'(m0));
      end
      if (in_valid && in_ready) begin
        if (cyc < 4) acc_early++;
        idx++;
      end
      cyc++;
    end
    step(); in_valid = 1'b0;
    check("t4_accepted_while_stalled", 32'(acc_early), 32'(2));
    check("t4_all_out", 32'(int'(n_out) - out0), 32'(5));

    // Reset with two results in flight.
    out_ready = 1'b0;
    step(); x = 15'd100; y = 15'd7; in_valid = 1'b1;
    step(); x = 15'd5;   y = 15'd9;
    step(); in_valid = 1'b0;
    @(negedge clk); check("t5_inflight_valid", 32'(out_valid), 32'(1));
    step(); rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'(0));
    check("t5_rst_diff", 32'(diff), 32'(0));
    check("t5_rst_in_ready", 32'(in_ready), 32'(0));
    step(); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("t5_no_stale", 32'(out_valid), 32'(0));
    end
    step(); x = 15'd32767; y = 15'd0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    wait_out("t5_after", 15'd32767, 1'b0);
    repeat (3) step();

    // Randomized traffic with random back-pressure.
    chk_ready = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!hold) begin
        case ($urandom_range(0, 5))
          0: x = 15'd0;
          1: x = 15'd32767;
          default: x = 15'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: y = 15'd0;
          1: y = 15'd32767;
          default: y = 15'($urandom);
        endcase
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hold = in_valid && !in_ready;
      check("occupancy_max", 32'(sb_q.size() <= 2), 32'(1));
    end
    step(); in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    chk_ready = 1'b0;
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
